osc_freq_meter_core: RTL and testbench

//  Next-generation oscillator measurement core, clocked entirely by TEST_CLK. Counts TEST_CLK cycles over a

---
 rtl/osc_meas_pkg.sv | 19 +
 rtl/ref_edge_sync.sv | 34 +++
 rtl/osc_freq_meter_core.sv | 147 ++++++++++++++
 tb/tb_osc_freq_meter_core.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/osc_meas_pkg.sv
// Shared definitions for the oscillator measurement core.
//  - state_t      : measurement FSM states
//  - CNT_W_DEF    : default cycle-counter / result width
//  - GATE_W_DEF   : default gate-length width
//  - SYNC_MIN/MAX : legal range of the REF_CLK synchroniser depth
package osc_meas_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      COUNT = 2'd2
   } state_t;

   localparam int CNT_W_DEF  = 24;
   localparam int GATE_W_DEF = 8;
   localparam int SYNC_MIN   = 2;
   localparam int SYNC_MAX   = 4;

endpackage

// File: rtl/ref_edge_sync.sv
// REF_CLK synchroniser and rising-edge detector, clocked by TEST_CLK.
// Ports:
//  TEST_CLK  in   sampling clock
//  OPB_RST   in   asynchronous, active-high reset
//  REF_CLK   in   asynchronous reference clock
//  ref_rise  out  one TEST_CLK-cycle pulse per synchronised REF_CLK rising edge
module ref_edge_sync
   import osc_meas_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic TEST_CLK,
   input  logic OPB_RST,
   input  logic REF_CLK,
   output logic ref_rise
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;

   always_ff @(posedge TEST_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], REF_CLK};
         prev <= sync[SYNC_STAGES-1];
      end
   end

   // prev is the edge register: high on the last sync stage, low one cycle behind.
   assign ref_rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/osc_freq_meter_core.sv
// Oscillator frequency meter core. Counts TEST_CLK cycles across a gate of
// N REF_CLK periods, single-shot or continuous, with saturation, limit check
// and a valid/ack result handshake.
// Ports:
//  TEST_CLK, OPB_RST       clock / async active-high reset
//  REF_CLK                 reference clock (synchronised internally)
//  start, abort            1-cycle command pulses
//  cfg_cont, cfg_gate      mode and gate length (0 means 1)
//  cfg_lo, cfg_hi          inclusive result limits
//  busy                    high in ARM or COUNT
//  result, result_valid    last gate count and its valid flag
//  result_ack              consume result
//  in_range, saturated     flags registered alongside result
//  overrun                 sticky: unacked result overwritten; cleared by start
module osc_freq_meter_core
   import osc_meas_pkg::*;
#(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int GATE_W      = GATE_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              TEST_CLK,
   input  logic              OPB_RST,
   input  logic              REF_CLK,
   input  logic              start,
   input  logic              abort,
   input  logic              cfg_cont,
   input  logic [GATE_W-1:0] cfg_gate,
   input  logic [CNT_W-1:0]  cfg_lo,
   input  logic [CNT_W-1:0]  cfg_hi,
   output logic              busy,
   output logic [CNT_W-1:0]  result,
   output logic              result_valid,
   input  logic              result_ack,
   output logic              in_range,
   output logic              saturated,
   output logic              overrun
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             state, state_n;
   logic               ref_rise;
   logic               term;
   logic [CNT_W-1:0]   cnt;
   logic [GATE_W-1:0]  gate_left;
   logic               sh_cont;
   logic [GATE_W-1:0]  sh_gate;
   logic [CNT_W-1:0]   sh_lo, sh_hi;
   logic [CNT_W-1:0]   res_n;
   logic               sat_n;

   function automatic logic [GATE_W-1:0] gate_eff(input logic [GATE_W-1:0] g);
      return (g == '0) ? GATE_W'(1) : g;
   endfunction

   ref_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .TEST_CLK (TEST_CLK),
      .OPB_RST  (OPB_RST),
      .REF_CLK  (REF_CLK),
      .ref_rise (ref_rise)
   );

   // The terminal cycle counts itself, hence cnt+1; clipped at all-ones.
   assign sat_n = (cnt == CNT_MAX);
   assign res_n = sat_n ? CNT_MAX : cnt + 1'b1;
   assign busy  = (state != IDLE);

   always_ff @(posedge TEST_CLK or posedge OPB_RST) begin
      if (OPB_RST) state <= IDLE;
      else         state <= state_n;
   end

   always_comb begin
      state_n = state;
      term    = 1'b0;
      case (state)
         IDLE:    if (start) state_n = ARM;
         ARM:     if (ref_rise) state_n = COUNT;
         COUNT:   if (ref_rise && gate_left == GATE_W'(1)) begin
                     term    = 1'b1;
                     state_n = sh_cont ? COUNT : IDLE;
                  end
         default: state_n = IDLE;
      endcase
      // abort wins over everything, including a terminal edge in the same cycle
      if (abort) begin
         state_n = IDLE;
         term    = 1'b0;
      end
   end

   always_ff @(posedge TEST_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         cnt          <= '0;
         gate_left    <= '0;
         sh_cont      <= 1'b0;
         sh_gate      <= '0;
         sh_lo        <= '0;
         sh_hi        <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         in_range     <= 1'b0;
         saturated    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (state == IDLE && start && !abort) begin
            sh_cont <= cfg_cont;
            sh_gate <= cfg_gate;
            sh_lo   <= cfg_lo;
            sh_hi   <= cfg_hi;
            overrun <= 1'b0;
         end

         if (state == ARM && ref_rise) begin
            cnt       <= '0;
            gate_left <= gate_eff(sh_gate);
         end else if (state == COUNT) begin
            if (term) begin
               // restart on the terminal edge itself so no cycle is lost between gates
               cnt <= '0;
               if (sh_cont) begin
                  sh_cont   <= cfg_cont;
                  sh_gate   <= cfg_gate;
                  sh_lo     <= cfg_lo;
                  sh_hi     <= cfg_hi;
                  gate_left <= gate_eff(cfg_gate);
               end
            end else begin
               if (!sat_n) cnt <= cnt + 1'b1;
               if (ref_rise) gate_left <= gate_left - 1'b1;
            end
         end

         if (term) begin
            result       <= res_n;
            saturated    <= sat_n;
            in_range     <= (res_n >= sh_lo) && (res_n <= sh_hi);
            result_valid <= 1'b1;
            if (result_valid && !result_ack) overrun <= 1'b1;
         end else if (result_ack) begin
            result_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_osc_freq_meter_core.sv
// Directed bench for osc_freq_meter_core: a 24-bit instance for the main
// scenarios and an 8-bit instance sharing the same stimulus for saturation.
module tb_osc_freq_meter_core;

   logic        TEST_CLK = 1'b0;
   logic        OPB_RST  = 1'b1;
   logic        REF_CLK  = 1'b0;
   logic        start = 1'b0, abort = 1'b0, result_ack = 1'b0;
   logic        cfg_cont = 1'b0;
   logic [7:0]  cfg_gate = 8'd1;
   logic [23:0] cfg_lo = '0, cfg_hi = '1;

   logic        busy, result_valid, in_range, saturated, overrun;
   logic [23:0] result;
   logic        busy8, result_valid8, in_range8, saturated8, overrun8;
   logic [7:0]  result8;

   int ref_period = 100;
   int ref_cnt    = 0;
   int passed = 0, total = 0;

   osc_freq_meter_core #(.CNT_W(24), .GATE_W(8), .SYNC_STAGES(2)) dut (
      .TEST_CLK(TEST_CLK), .OPB_RST(OPB_RST), .REF_CLK(REF_CLK),
      .start(start), .abort(abort), .cfg_cont(cfg_cont), .cfg_gate(cfg_gate),
      .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .busy(busy), .result(result),
      .result_valid(result_valid), .result_ack(result_ack),
      .in_range(in_range), .saturated(saturated), .overrun(overrun)
   );

   osc_freq_meter_core #(.CNT_W(8), .GATE_W(8), .SYNC_STAGES(3)) dut8 (
      .TEST_CLK(TEST_CLK), .OPB_RST(OPB_RST), .REF_CLK(REF_CLK),
      .start(start), .abort(abort), .cfg_cont(cfg_cont), .cfg_gate(cfg_gate),
      .cfg_lo(cfg_lo[7:0]), .cfg_hi(cfg_hi[7:0]), .busy(busy8), .result(result8),
      .result_valid(result_valid8), .result_ack(result_ack),
      .in_range(in_range8), .saturated(saturated8), .overrun(overrun8)
   );

   always #5 TEST_CLK = ~TEST_CLK;

   // REF_CLK changes on TEST_CLK falling edges: rising edges exactly ref_period cycles apart.
   always @(negedge TEST_CLK) begin
      if (ref_cnt >= ref_period - 1) ref_cnt = 0;
      else                           ref_cnt = ref_cnt + 1;
      REF_CLK = (ref_cnt < ref_period / 2);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else passed++;
   endtask

   task automatic pulse_start();
      @(negedge TEST_CLK) start = 1'b1;
      @(negedge TEST_CLK) start = 1'b0;
   endtask
   task automatic pulse_abort();
      @(negedge TEST_CLK) abort = 1'b1;
      @(negedge TEST_CLK) abort = 1'b0;
   endtask
   task automatic pulse_ack();
      @(negedge TEST_CLK) result_ack = 1'b1;
      @(negedge TEST_CLK) result_ack = 1'b0;
   endtask

   task automatic wait_valid(input bit use8, input int budget, input string name);
      int i;
      for (i = 0; i < budget; i++) begin
         @(negedge TEST_CLK);
         if (use8 ? result_valid8 : result_valid) break;
      end
      total++;
      if (i >= budget) $display("FAIL %s: result_valid never rose within %0d cycles", name, budget);
      else passed++;
   endtask

   task automatic test_reset();
      repeat (5) @(negedge TEST_CLK);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_flags", {in_range, saturated, overrun}, 0);
      OPB_RST = 1'b0;
      repeat (3) @(negedge TEST_CLK);
   endtask

   task automatic test_single_shot();
      ref_period = 100; cfg_gate = 4; cfg_cont = 0; cfg_lo = 0; cfg_hi = 1000;
      pulse_start();
      chk("ss_busy_running", busy, 1);
      wait_valid(0, 800, "ss_wait");
      chk("ss_result", result, 400);
      chk("ss_busy_done", busy, 0);
      chk("ss_in_range", in_range, 1);
      chk("ss_saturated", saturated, 0);
      pulse_ack();
      chk("ss_ack_clears", result_valid, 0);
   endtask

   task automatic test_continuous_ack();
      ref_period = 100; cfg_gate = 1; cfg_cont = 1; cfg_lo = 0; cfg_hi = 1000;
      pulse_start();
      for (int k = 0; k < 3; k++) begin
         wait_valid(0, 300, "cont_wait");
         chk("cont_result", result, 100);
         pulse_ack();
         chk("cont_ack_clears", result_valid, 0);
      end
      chk("cont_busy", busy, 1);
      chk("cont_no_overrun", overrun, 0);
      pulse_abort();
      chk("cont_abort_idle", busy, 0);
      cfg_cont = 0;
      if (result_valid) pulse_ack();
   endtask

   task automatic test_overrun();
      int i;
      ref_period = 100; cfg_gate = 1; cfg_cont = 1;
      pulse_start();
      wait_valid(0, 300, "ovr_first");
      for (i = 0; i < 250; i++) begin
         @(negedge TEST_CLK);
         if (overrun) break;
      end
      chk("ovr_set", overrun, 1);
      chk("ovr_result", result, 100);
      chk("ovr_valid_held", result_valid, 1);
      pulse_abort();
      chk("ovr_sticky_after_abort", overrun, 1);
      chk("ovr_abort_keeps_valid", result_valid, 1);
      cfg_cont = 0;
      pulse_start();
      chk("ovr_cleared_by_start", overrun, 0);
      pulse_abort();
      pulse_ack();
      chk("ovr_final_valid", result_valid, 0);
   endtask

   task automatic test_saturation();
      ref_period = 300; cfg_gate = 1; cfg_cont = 0; cfg_lo = 0; cfg_hi = 200;
      pulse_start();
      wait_valid(1, 1000, "sat_wait");
      chk("sat_result8", result8, 255);
      chk("sat_flag8", saturated8, 1);
      chk("sat_in_range8", in_range8, 0);
      repeat (3) @(negedge TEST_CLK);
      chk("sat_result24", result, 300);
      chk("sat_flag24", saturated, 0);
      pulse_ack();
      chk("sat_ack8", result_valid8, 0);
   endtask

   task automatic test_limits();
      cfg_gate = 4; cfg_cont = 0; cfg_lo = 399; cfg_hi = 401;
      ref_period = 100;
      pulse_start();
      wait_valid(0, 800, "lim_wait_a");
      chk("lim_400", result, 400);
      chk("lim_in", in_range, 1);
      pulse_ack();
      ref_period = 101;
      pulse_start();
      wait_valid(0, 900, "lim_wait_b");
      chk("lim_404", result, 404);
      chk("lim_out", in_range, 0);
      pulse_ack();
   endtask

   task automatic test_abort_reset_gate0();
      ref_period = 100; cfg_gate = 4; cfg_cont = 0; cfg_lo = 0; cfg_hi = 1000;
      pulse_start();
      repeat (150) @(negedge TEST_CLK);
      pulse_abort();
      chk("ab_busy", busy, 0);
      repeat (450) @(negedge TEST_CLK);
      chk("ab_no_valid", result_valid, 0);
      chk("ab_result_kept", result, 404);
      pulse_start();
      repeat (150) @(negedge TEST_CLK);
      OPB_RST = 1'b1;
      #1;
      chk("rs_busy", busy, 0);
      chk("rs_result", result, 0);
      @(negedge TEST_CLK) OPB_RST = 1'b0;
      repeat (450) @(negedge TEST_CLK);
      chk("rs_no_valid", result_valid, 0);
      cfg_gate = 0;
      pulse_start();
      wait_valid(0, 400, "g0_wait");
      chk("g0_result", result, 100);
      pulse_ack();
   endtask

   initial begin
      test_reset();
      test_single_shot();
      test_continuous_ack();
      test_overrun();
      test_saturation();
      test_limits();
      test_abort_reset_gate0();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
